// File: rtl/array_clone_if.sv
// ---------------------------------------------------------------------------
// array_clone_if
// Host-side bus of the array clone engine: source write port, clone control,
// status, and the registered destination read port.
//   master : host (drives wr_*, start, mode, rd_row/rd_col)
//   slave  : engine (drives busy, done, rd_data, mismatch)
// Index widths are derived from ROWS/COLS (minimum 1 bit) and must match the
// parameters given to the engine instance that uses this bus.
// ---------------------------------------------------------------------------
interface array_clone_if #(
  parameter int DATA_W = 4,
  parameter int ROWS   = 8,
  parameter int COLS   = 6
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic              wr_en;
  logic [RW-1:0]     wr_row;
  logic [CW-1:0]     wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [RW-1:0]     rd_row;
  logic [CW-1:0]     rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              mismatch;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, start, mode, rd_row, rd_col,
    input  busy, done, rd_data, mismatch
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, start, mode, rd_row, rd_col,
    output busy, done, rd_data, mismatch
  );
endinterface

// File: rtl/array_clone_engine.sv
// ---------------------------------------------------------------------------
// array_clone_engine
// Copies a ROWS x COLS source array into a destination array, one element per
// cycle in row-major order, through one of four index mappings:
//   00 copy, 01 column-reverse, 10 row-reverse, 11 transpose (square only;
//   on non-square arrays 11 behaves as 00).
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset (aborts a clone in flight)
//   bus    : array_clone_if.slave
//            wr_en/wr_row/wr_col/wr_data : source write (IDLE and DONE only)
//            start/mode                  : begin clone (sampled in IDLE only)
//            busy/done                   : status, done is a 1-cycle pulse
//            rd_row/rd_col/rd_data       : registered destination read
//            mismatch                    : sticky verify failure flag
// Build option:
//   CLONE_VERIFY_EN : adds a VERIFY pass after COPY that re-reads every
//                     mapped destination element and compares it with the
//                     source; without it mismatch is tied to 0.
// ---------------------------------------------------------------------------
module array_clone_engine #(
  parameter int DATA_W = 4,
  parameter int ROWS   = 8,
  parameter int COLS   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  array_clone_if.slave   bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam bit             TRANSPOSE_OK = (ROWS == COLS);
  localparam logic [RW:0]    ROWS_L  = (RW+1)'(ROWS);
  localparam logic [CW:0]    COLS_L  = (CW+1)'(COLS);
  localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COPY   = 2'd1;
`ifdef CLONE_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
`endif
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] M_COPY = 2'b00;
  localparam logic [1:0] M_CREV = 2'b01;
  localparam logic [1:0] M_RREV = 2'b10;
  localparam logic [1:0] M_TRAN = 2'b11;

  logic [DATA_W-1:0] src_q [ROWS][COLS];
  logic [DATA_W-1:0] dst_q [ROWS][COLS];

  logic [1:0]        state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [RW-1:0]     map_r;
  logic [CW-1:0]     map_c;
  logic              last_col, last_elem;
  logic              wr_ok, rd_ok;

  assign last_col  = (c_q == COL_MAX);
  assign last_elem = last_col && (r_q == ROW_MAX);

  // Source is writable only while no clone is walking it, so a clone always
  // sees a frozen snapshot.
  assign wr_ok = bus.wr_en && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                 ({1'b0, bus.wr_row} < ROWS_L) && ({1'b0, bus.wr_col} < COLS_L);
  assign rd_ok = ({1'b0, bus.rd_row} < ROWS_L) && ({1'b0, bus.rd_col} < COLS_L);

  // Destination coordinate for the current walk position.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps a latch from being inferred.
  always_comb begin
    map_r = r_q;
    map_c = c_q;
    case (mode_q)
      M_CREV: map_c = COL_MAX - c_q;
      M_RREV: map_r = ROW_MAX - r_q;
      M_TRAN: begin
        // Only reachable when ROWS == COLS, so the casts never truncate.
        map_r = RW'(c_q);
        map_c = CW'(r_q);
      end
      default: ;
    endcase
  end

`ifdef CLONE_VERIFY_EN
  logic mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    mode_d  = mode_q;
`ifdef CLONE_VERIFY_EN
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_COPY;
          r_d     = '0;
          c_d     = '0;
          // Transpose on a non-square array degrades to a plain copy.
          mode_d  = ((bus.mode == M_TRAN) && !TRANSPOSE_OK) ? M_COPY : bus.mode;
`ifdef CLONE_VERIFY_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      S_COPY: begin
`ifdef CLONE_VERIFY_EN
        if (last_elem) state_d = S_VERIFY;
`else
        if (last_elem) state_d = S_DONE;
`endif
      end
`ifdef CLONE_VERIFY_EN
      S_VERIFY: begin
        if (dst_q[map_r][map_c] != src_q[r_q][c_q]) mismatch_d = 1'b1;
        if (last_elem) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Row-major walk shared by COPY and VERIFY; it wraps to (0,0) after the
    // last element, which is exactly where a following VERIFY pass starts.
    if (bus.busy) begin
      if (last_col) begin
        c_d = '0;
        r_d = (r_q == ROW_MAX) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      mode_q    <= M_COPY;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      mode_q    <= mode_d;
      rd_data_q <= rd_ok ? dst_q[bus.rd_row][bus.rd_col] : '0;
    end
  end

`ifdef CLONE_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end
  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif

  // NOTE: the arrays are storage, not control state; they carry no reset so
  // they map onto plain RAM/flop arrays without a reset network.
  always_ff @(posedge clk) begin
    if (wr_ok) src_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
    if (state_q == S_COPY) dst_q[map_r][map_c] <= src_q[r_q][c_q];
  end

`ifdef CLONE_VERIFY_EN
  assign bus.busy = (state_q == S_COPY) || (state_q == S_VERIFY);
`else
  assign bus.busy = (state_q == S_COPY);
`endif
  assign bus.done    = (state_q == S_DONE);
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_array_clone_engine.sv
// ---------------------------------------------------------------------------
// tb_array_clone_engine
// Directed bench for array_clone_engine. Instance A uses the default 8x6x4
// geometry, instance B a square 4x4x8 geometry for the transpose mode.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_array_clone_engine;
  localparam int AN = 48;
  localparam int BN = 16;
`ifdef CLONE_VERIFY_EN
  localparam int A_LAT = 2*AN + 1;
  localparam int B_LAT = 2*BN + 1;
`else
  localparam int A_LAT = AN + 1;
  localparam int B_LAT = BN + 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  array_clone_if #(.DATA_W(4), .ROWS(8), .COLS(6)) a_if ();
  array_clone_if #(.DATA_W(8), .ROWS(4), .COLS(4)) b_if ();

  array_clone_engine #(.DATA_W(4), .ROWS(8), .COLS(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );
  array_clone_engine #(.DATA_W(8), .ROWS(4), .COLS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Hand-written reference: value held by dst[r][c] after a clone in mode m.
  function automatic logic [3:0] a_src(input int r, input int c);
    return 4'((r*6 + c + 3) % 16);
  endfunction

  function automatic logic [3:0] a_exp(input logic [1:0] m, input int r, input int c);
    int sr, sc;
    sr = r; sc = c;
    if (m == 2'b01) sc = 5 - c;
    if (m == 2'b10) sr = 7 - r;
    return a_src(sr, sc);
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs;
    a_if.wr_en = 0; a_if.wr_row = '0; a_if.wr_col = '0; a_if.wr_data = '0;
    a_if.start = 0; a_if.mode = '0; a_if.rd_row = '0; a_if.rd_col = '0;
    b_if.wr_en = 0; b_if.wr_row = '0; b_if.wr_col = '0; b_if.wr_data = '0;
    b_if.start = 0; b_if.mode = '0; b_if.rd_row = '0; b_if.rd_col = '0;
  endtask

  task automatic a_load;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        a_if.wr_en = 1; a_if.wr_row = 3'(r); a_if.wr_col = 3'(c);
        a_if.wr_data = a_src(r, c);
      end
    @(negedge clk);
    a_if.wr_en = 0;
  endtask

  task automatic a_start(input logic [1:0] m);
    @(negedge clk);
    a_if.start = 1; a_if.mode = m;
    @(negedge clk);
    a_if.start = 0;
  endtask

  task automatic a_read(input int r, input int c, output logic [3:0] d);
    @(negedge clk);
    a_if.rd_row = 3'(r); a_if.rd_col = 3'(c);
    @(negedge clk);
    d = a_if.rd_data;
  endtask

  task automatic a_check_dst(input logic [1:0] m, input string tag);
    logic [3:0] d;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++) begin
        a_read(r, c, d);
        cmp($sformatf("%s dst[%0d][%0d]", tag, r, c), 32'(d), 32'(a_exp(m, r, c)));
      end
  endtask

  // Runs one clone on A and checks its busy/done timing. A non-zero inject
  // cycle drives a source write and a second start while the copy is running.
  task automatic a_clone(input logic [1:0] m, input int inject, input string tag);
    int busy_cnt, done_at, done_cnt;
    logic busy_at_done;
    busy_cnt = 0; done_at = -1; done_cnt = 0; busy_at_done = 0;
    a_start(m);
    for (int k = 1; k <= A_LAT + 3; k++) begin
      if (inject > 0 && k == inject) begin
        a_if.wr_en = 1; a_if.wr_row = 3'd0; a_if.wr_col = 3'd0; a_if.wr_data = 4'hF;
        a_if.start = 1; a_if.mode = 2'b01;
      end
      if (inject > 0 && k == inject + 1) begin
        a_if.wr_row = 3'd7; a_if.wr_col = 3'd5; a_if.start = 0;
      end
      if (inject > 0 && k == inject + 2) a_if.wr_en = 0;
      if (a_if.busy === 1'b1) busy_cnt++;
      if (a_if.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
        if (a_if.busy !== 1'b0) busy_at_done = 1;
      end
      @(negedge clk);
    end
    cmp({tag, " busy cycles"}, 32'(busy_cnt), 32'(A_LAT - 1));
    cmp({tag, " done cycle"}, 32'(done_at), 32'(A_LAT));
    cmp({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    cmp({tag, " busy with done"}, 32'(busy_at_done), 32'd0);
    cmp({tag, " mismatch"}, 32'(a_if.mismatch), 32'd0);
  endtask

  task automatic a_wait_done(inout int k, input string tag);
    while (a_if.done !== 1'b1 && k < A_LAT + 3) begin
      @(negedge clk);
      k++;
    end
    cmp({tag, " done cycle"}, 32'(k), 32'(A_LAT));
  endtask

  task automatic test_reset;
    rst_n = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    cmp("reset a.busy", 32'(a_if.busy), 32'd0);
    cmp("reset a.done", 32'(a_if.done), 32'd0);
    cmp("reset a.rd_data", 32'(a_if.rd_data), 32'd0);
    cmp("reset a.mismatch", 32'(a_if.mismatch), 32'd0);
    cmp("reset b.busy", 32'(b_if.busy), 32'd0);
    cmp("reset b.rd_data", 32'(b_if.rd_data), 32'd0);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_copy;
    a_load();
    a_clone(2'b00, 0, "copy");
    a_check_dst(2'b00, "copy");
  endtask

  task automatic test_col_reverse;
    logic [3:0] d;
    a_clone(2'b01, 0, "crev");
    a_read(0, 0, d); cmp("crev dst[0][0] hand", 32'(d), 32'h8);
    a_read(0, 5, d); cmp("crev dst[0][5] hand", 32'(d), 32'h3);
    a_check_dst(2'b01, "crev");
  endtask

  task automatic test_row_reverse;
    logic [3:0] d;
    a_clone(2'b10, 0, "rrev");
    a_read(7, 0, d); cmp("rrev dst[7][0] hand", 32'(d), 32'h3);
    a_check_dst(2'b10, "rrev");
  endtask

  task automatic test_transpose_fallback;
    a_clone(2'b11, 0, "tfall");
    a_check_dst(2'b00, "tfall");
  endtask

  task automatic test_transpose;
    int busy_cnt, done_at;
    logic [7:0] d;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        b_if.wr_en = 1; b_if.wr_row = 2'(r); b_if.wr_col = 2'(c);
        b_if.wr_data = 8'(16*r + c);
      end
    @(negedge clk);
    b_if.wr_en = 0; b_if.start = 1; b_if.mode = 2'b11;
    @(negedge clk);
    b_if.start = 0;
    busy_cnt = 0; done_at = -1;
    for (int k = 1; k <= B_LAT + 2; k++) begin
      if (b_if.busy === 1'b1) busy_cnt++;
      if (b_if.done === 1'b1 && done_at < 0) done_at = k;
      @(negedge clk);
    end
    cmp("tran busy cycles", 32'(busy_cnt), 32'(B_LAT - 1));
    cmp("tran done cycle", 32'(done_at), 32'(B_LAT));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        b_if.rd_row = 2'(r); b_if.rd_col = 2'(c);
        @(negedge clk);
        d = b_if.rd_data;
        cmp($sformatf("tran dst[%0d][%0d]", r, c), 32'(d), 32'(16*c + r));
        if (r == 1 && c == 2) cmp("tran dst[1][2] hand", 32'(d), 32'h21);
        if (r == 3 && c == 0) cmp("tran dst[3][0] hand", 32'(d), 32'h03);
      end
  endtask

  task automatic test_out_of_range;
    logic [3:0] d;
    @(negedge clk);
    a_if.wr_en = 1; a_if.wr_row = 3'd3; a_if.wr_col = 3'd6; a_if.wr_data = 4'h9;
    @(negedge clk);
    a_if.wr_en = 0;
    a_read(0, 6, d); cmp("oor rd col 6", 32'(d), 32'h0);
    a_read(5, 7, d); cmp("oor rd col 7", 32'(d), 32'h0);
    a_read(2, 5, d); cmp("in-range rd after oor", 32'(d), 32'(a_exp(2'b00, 2, 5)));
  endtask

  task automatic test_freeze;
    logic [3:0] d;
    a_clone(2'b10, 0, "pre-freeze");
    a_clone(2'b00, 3, "freeze");
    a_read(0, 0, d); cmp("freeze dst[0][0] hand", 32'(d), 32'h3);
    a_check_dst(2'b00, "freeze");
    // A fresh clone copies the source again: the mid-copy writes must be gone.
    a_clone(2'b00, 0, "refreeze");
    a_read(0, 0, d); cmp("frozen src[0][0]", 32'(d), 32'h3);
    a_read(7, 5, d); cmp("frozen src[7][5]", 32'(d), 32'h2);
  endtask

  task automatic test_back_to_back;
    int k;
    a_start(2'b00);
    k = 1;
    a_wait_done(k, "b2b first");
    // Start held through the DONE cycle is ignored, then taken in IDLE.
    a_if.start = 1; a_if.mode = 2'b01;
    @(negedge clk);
    cmp("b2b start in DONE ignored", 32'(a_if.busy), 32'd0);
    @(negedge clk);
    a_if.start = 0;
    cmp("b2b start in IDLE accepted", 32'(a_if.busy), 32'd1);
    k = 1;
    a_wait_done(k, "b2b second");
    @(negedge clk);
    a_check_dst(2'b01, "b2b");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a_if.rd_row = 3'd0; a_if.rd_col = 3'd0;
    a_start(2'b00);
    for (int k = 1; k < 10; k++) @(negedge clk);
    cmp("midrst busy before", 32'(a_if.busy), 32'd1);
    cmp("midrst rd_data before", 32'(a_if.rd_data), 32'h3);
    rst_n = 0;
    #1;
    cmp("midrst busy", 32'(a_if.busy), 32'd0);
    cmp("midrst done", 32'(a_if.done), 32'd0);
    cmp("midrst rd_data", 32'(a_if.rd_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cmp("midrst idle after", 32'(a_if.busy), 32'd0);
    a_clone(2'b01, 0, "postrst");
    a_check_dst(2'b01, "postrst");
  endtask

`ifdef CLONE_VERIFY_EN
  task automatic test_verify_mismatch;
    int k;
    a_start(2'b00);
    k = 1;
    while (k < AN + 5) begin
      @(negedge clk);
      k++;
    end
    cmp("verify busy in VERIFY", 32'(a_if.busy), 32'd1);
    dut_a.dst_q[7][5] = ~a_src(7, 5);
    a_wait_done(k, "verify bad");
    cmp("verify mismatch set", 32'(a_if.mismatch), 32'd1);
    @(negedge clk);
    cmp("verify mismatch sticky", 32'(a_if.mismatch), 32'd1);
    a_start(2'b00);
    cmp("verify mismatch cleared", 32'(a_if.mismatch), 32'd0);
    k = 1;
    a_wait_done(k, "verify clean");
    cmp("verify mismatch clean", 32'(a_if.mismatch), 32'd0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_copy();
    test_col_reverse();
    test_row_reverse();
    test_transpose_fallback();
    test_transpose();
    test_out_of_range();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
`ifdef CLONE_VERIFY_EN
    test_verify_mismatch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
